// File: rtl/fma_arb_pkg.sv
// Shared types and helpers for the FMA issue arbiter: word/tag types and
// pointer/counter arithmetic.
package fma_arb_pkg;

    localparam int FWORD_W   = 32;
    localparam int FMA_DELAY = 21;
    // Tag ID width covers the largest supported requester count (16)
    localparam int ID_W      = 4;

    typedef logic [FWORD_W-1:0] fword_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } fma_tag_t;

    // Round-robin successor with explicit wrap, valid for any n
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fma_issue_arbiter_rr.sv
// Combinational round-robin arbiter: scans req starting at ptr and returns
// the first set position as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // First requester at or after ptr, wrapping modulo N
    always_comb begin
        int cand;
        logic [IW-1:0] cand_s;
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        cand_s = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            cand_s = IW'(cand);
            if (!any && req[cand_s]) begin
                any           = 1'b1;
                idx           = cand_s;
                grant[cand_s] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/fma_issue_arbiter.sv
// Shares one pipelined FMA among N_REQ requesters with a parallel owner tag
// pipe and a single backpressured result port. FMA_ARB_PERF_EN adds counters.
module fma_issue_arbiter
    import fma_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int DELAY = FMA_DELAY,
    parameter  int FW    = FWORD_W,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*FW-1:0] req_a,
    input  logic [N_REQ*FW-1:0] req_b,
    input  logic [N_REQ*FW-1:0] req_c,
    input  logic [N_REQ-1:0]   req_mode,
    output logic [FW-1:0]      fma_a,
    output logic [FW-1:0]      fma_b,
    output logic [FW-1:0]      fma_c,
    output logic               fma_mode,
    output logic               fma_clken,
    input  logic [FW-1:0]      fma_out,
    output logic               res_valid,
    output logic [IW-1:0]      res_id,
    output logic [FW-1:0]      res_data,
    input  logic               res_ready
`ifdef FMA_ARB_PERF_EN
    ,
    output logic [31:0]        perf_issued,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_bubble
`endif
);

    fma_tag_t          tag_r [DELAY];
    fma_tag_t          tag_in_s;
    logic [IW-1:0]     ptr_r;
    logic [N_REQ-1:0]  grant_s;
    logic [IW-1:0]     gidx_s;
    logic              gany_s;
    logic              stall_s;
    logic              adv_s;
    logic              issue_s;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s),
        .any   (gany_s)
    );

    // Pipe advance control; reset forces the FMA and requesters idle at once
    always_comb begin
        stall_s = tag_r[DELAY-1].valid & ~res_ready;
        adv_s   = rstn & ~stall_s;
        issue_s = adv_s & gany_s;
    end

    // Tag entering the pipe: a bubble when nobody is granted
    always_comb begin
        tag_in_s       = '0;
        tag_in_s.valid = gany_s;
        tag_in_s.id    = ID_W'(gidx_s);
    end

    // Handshake and result presentation
    always_comb begin
        fma_clken = adv_s;
        req_ready = adv_s ? grant_s : '0;
        res_valid = tag_r[DELAY-1].valid;
        res_id    = tag_r[DELAY-1].id[IW-1:0];
        res_data  = fma_out;
    end

    // Operand steering from the granted requester
    always_comb begin
        fma_a    = '0;
        fma_b    = '0;
        fma_c    = '0;
        fma_mode = 1'b0;
        if (gany_s) begin
            fma_a    = req_a[int'(gidx_s)*FW +: FW];
            fma_b    = req_b[int'(gidx_s)*FW +: FW];
            fma_c    = req_c[int'(gidx_s)*FW +: FW];
            fma_mode = req_mode[gidx_s];
        end else begin
            fma_mode = 1'b0;
        end
    end

    // Owner tag shift register, lock-stepped with the FMA pipe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DELAY; i++) begin
                tag_r[i] <= '0;
            end
        end else if (adv_s) begin
            tag_r[0] <= tag_in_s;
            for (int i = 1; i < DELAY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end else begin
            for (int i = 0; i < DELAY; i++) begin
                tag_r[i] <= tag_r[i];
            end
        end
    end

    // Round-robin pointer moves past the winner only when an op issues
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= '0;
        end else if (issue_s) begin
            ptr_r <= IW'(rr_next(int'(gidx_s), N_REQ));
        end else begin
            ptr_r <= ptr_r;
        end
    end

`ifdef FMA_ARB_PERF_EN
    // Saturating event counters: issues, stall cycles, bubble-at-output cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_issued <= 32'd0;
            perf_stall  <= 32'd0;
            perf_bubble <= 32'd0;
        end else begin
            perf_issued <= issue_s ? sat_inc(perf_issued) : perf_issued;
            perf_stall  <= stall_s ? sat_inc(perf_stall) : perf_stall;
            perf_bubble <= tag_r[DELAY-1].valid ? perf_bubble : sat_inc(perf_bubble);
        end
    end
`endif

endmodule

// File: tb/tb_fma_issue_arbiter.sv
// Randomized self-checking bench for fma_issue_arbiter with an integer
// stand-in FMA pipe and a transaction-level reference model.
module tb_fma_issue_arbiter;

    localparam int N     = 4;
    localparam int DELAY = 21;
    localparam int FW    = 32;
    localparam int IW    = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*FW-1:0]   req_a = '0, req_b = '0, req_c = '0;
    logic [N-1:0]      req_mode = '0;
    logic [FW-1:0]     fma_a, fma_b, fma_c, fma_out, res_data;
    logic              fma_mode, fma_clken, res_valid;
    logic              res_ready = 1'b1;
    logic [IW-1:0]     res_id;
`ifdef FMA_ARB_PERF_EN
    logic [31:0]       perf_issued, perf_stall, perf_bubble;
`endif

    always #5 clk = ~clk;

    fma_issue_arbiter #(.N_REQ(N), .DELAY(DELAY), .FW(FW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_mode(req_mode),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_mode(fma_mode),
        .fma_clken(fma_clken), .fma_out(fma_out),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .res_ready(res_ready)
`ifdef FMA_ARB_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_bubble(perf_bubble)
`endif
    );

    // Integer stand-in for the FMA: DELAY stages, advancing on fma_clken
    logic [FW-1:0] fpipe [DELAY];
    always @(posedge clk) begin
        if (fma_clken) begin
            fpipe[0] <= fma_mode ? fma_a * fma_b + fma_c : fma_a * fma_b - fma_c;
            for (int i = 1; i < DELAY; i++) fpipe[i] <= fpipe[i-1];
        end
    end
    assign fma_out = fpipe[DELAY-1];

    // Reference model: ops keyed by the advance count at which they issued
    int             vectors = 0, miscompares = 0;
    int             m_ptr, m_adv, m_g;
    bit             m_stall, m_ev;
    int             m_issued, m_stalls, m_bubbles;
    logic [IW-1:0]  exp_id  [int];
    logic [FW-1:0]  exp_dat [int];
    logic           s_valid, s_clken;
    logic [IW-1:0]  s_id;
    logic [FW-1:0]  s_data;
    logic [N-1:0]   s_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_adv = 0; m_g = -1; m_stall = 0; m_ev = 0;
        m_issued = 0; m_stalls = 0; m_bubbles = 0;
        exp_id.delete();
        exp_dat.delete();
    endtask

    task automatic compare();
        logic [N-1:0] er;
        int key;
        key     = m_adv - DELAY + 1;
        m_ev    = exp_id.exists(key);
        m_stall = m_ev && !res_ready;
        m_g     = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_g < 0 && req_valid[c]) m_g = c;
        end
        s_valid = res_valid; s_id = res_id; s_data = res_data;
        s_ready = req_ready; s_clken = fma_clken;
        chk("res_valid", res_valid, m_ev);
        if (m_ev) begin
            chk("res_id", res_id, exp_id[key]);
            chk("res_data", res_data, exp_dat[key]);
        end
        chk("fma_clken", fma_clken, !m_stall);
        er = '0;
        if (!m_stall && m_g >= 0) er[m_g] = 1'b1;
        chk("req_ready", req_ready, er);
        if (m_g >= 0) begin
            chk("fma_a", fma_a, req_a[m_g*FW +: FW]);
            chk("fma_b", fma_b, req_b[m_g*FW +: FW]);
            chk("fma_c", fma_c, req_c[m_g*FW +: FW]);
            chk("fma_mode", fma_mode, req_mode[m_g]);
        end else begin
            chk("fma_a_idle", fma_a, 0);
            chk("fma_mode_idle", fma_mode, 0);
        end
`ifdef FMA_ARB_PERF_EN
        chk("perf_issued", perf_issued, m_issued);
        chk("perf_stall", perf_stall, m_stalls);
        chk("perf_bubble", perf_bubble, m_bubbles);
`endif
    endtask

    task automatic model_edge();
        int key;
        logic [FW-1:0] a, b, c;
        if (m_stall) begin
            m_stalls++;
        end else begin
            if (m_g >= 0) begin
                a = req_a[m_g*FW +: FW]; b = req_b[m_g*FW +: FW]; c = req_c[m_g*FW +: FW];
                key = m_adv + 1;
                exp_id[key]  = IW'(m_g);
                exp_dat[key] = req_mode[m_g] ? a * b + c : a * b - c;
                m_ptr = (m_g + 1) % N;
                m_issued++;
            end
            key = m_adv - DELAY + 1;
            if (exp_id.exists(key)) begin
                exp_id.delete(key);
                exp_dat.delete(key);
            end
            m_adv++;
        end
        if (!m_ev) m_bubbles++;
    endtask

    task automatic step();
        #1;
        compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        m_reset();
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fma_clken", fma_clken, 0);
        chk("rst_res_id", res_id, 0);
`ifdef FMA_ARB_PERF_EN
        chk("rst_perf_issued", perf_issued, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*FW +: FW] = $urandom;
            req_b[i*FW +: FW] = $urandom;
            req_c[i*FW +: FW] = $urandom;
        end
        req_mode = N'($urandom);
    endtask

    int            lat, got_id, got_dat, nres, nstall, stall_left;
    bit            stalled_once;
    int            ids [$];

    initial begin
        @(negedge clk);
        req_valid = 4'hF;
        rand_ops();
        do_reset();

        // Single op from requester 2: 2*3+1, then 2*3-1
        for (int pass = 0; pass < 2; pass++) begin
            req_a[2*FW +: FW] = 32'd2; req_b[2*FW +: FW] = 32'd3; req_c[2*FW +: FW] = 32'd1;
            req_mode[2] = (pass == 0) ? 1'b1 : 1'b0;
            req_valid = 4'b0100; res_ready = 1'b1;
            lat = -1; got_id = -1; got_dat = -1;
            for (int cyc = 0; cyc < 40; cyc++) begin
                step();
                if (cyc == 0) req_valid = 4'b0000;
                if (s_valid && lat < 0) begin
                    lat = cyc; got_id = int'(s_id); got_dat = int'(s_data);
                end
            end
            chk("single_latency", lat, 21);
            chk("single_id", got_id, 2);
            chk("single_data", got_dat, (pass == 0) ? 7 : 5);
        end

        // Fairness: all four valid for 8 cycles
        do_reset();
        req_valid = 4'hF; rand_ops();
        ids.delete(); lat = -1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            step();
            if (cyc < 8) chk("rr_grant", oh2i(s_ready), cyc % 4);
            if (cyc == 7) req_valid = 4'h0;
            else if (cyc < 7) rand_ops();
            if (s_valid) begin
                if (lat < 0) lat = cyc;
                ids.push_back(int'(s_id));
            end
        end
        chk("rr_first_result", lat, 21);
        chk("rr_result_count", ids.size(), 8);
        foreach (ids[i]) chk("rr_result_order", ids[i], i % 4);

        // Backpressure: 5 stalled cycles while results are valid
        do_reset();
        req_valid = 4'hF; rand_ops(); res_ready = 1'b1;
        ids.delete(); nstall = 0; stall_left = 0; stalled_once = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            step();
            if (s_valid && res_ready) ids.push_back(int'(s_id));
            if (!s_clken) nstall++;
            if (cyc == 7) req_valid = 4'h0;
            else if (cyc < 7) rand_ops();
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    res_ready = 1'b1; req_valid = 4'h0;
                end
            end else if (s_valid && !stalled_once) begin
                stalled_once = 1; stall_left = 5; res_ready = 1'b0; req_valid = 4'b0010;
            end
        end
        chk("bp_stall_cycles", nstall, 5);
        chk("bp_result_count", ids.size(), 8);
        foreach (ids[i]) chk("bp_result_order", ids[i], i % 4);
`ifdef FMA_ARB_PERF_EN
        chk("bp_perf_stall", perf_stall, 5);
        chk("bp_perf_issued", perf_issued, 8);
`endif

        // Sparse requests with random ready, including ready low on bubbles
        do_reset();
        for (int cyc = 0; cyc < 90; cyc++) begin
            req_valid = (cyc % 3 == 0) ? N'($urandom_range(1, 15)) : 4'h0;
            res_ready = 1'(($urandom & 1));
            rand_ops();
            step();
        end

        // Fully random traffic with a reset in the middle
        for (int cyc = 0; cyc < 600; cyc++) begin
            req_valid = N'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            if (cyc == 300) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
